// File: rtl/camera_timing_pkg.sv
// Shared camera timing definitions: FSM state encoding and the ROI window
// test used by the sync source.
package camera_timing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    HBLANK = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  // True when (x, y) lies inside the half-open window starting at
  // (x_lo, y_lo) with size x_len by y_len.
  function automatic logic in_roi_window(input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic [31:0] x_lo,
                                         input logic [31:0] x_len,
                                         input logic [31:0] y_lo,
                                         input logic [31:0] y_len);
    return (x >= x_lo) && (x < x_lo + x_len) &&
           (y >= y_lo) && (y < y_lo + y_len);
  endfunction

endpackage

// File: rtl/vsync_hsync_source_sync_counter.sv
// Frame timing engine: IDLE/VBLANK/HBLANK/ACTIVE sequencing with the pixel
// (x), line (y) and blanking counters. Counters never wrap inside a frame.
module sync_counter
  import camera_timing_pkg::*;
#(
  parameter int xmax    = 324,
  parameter int ymax    = 244,
  parameter int h_blank = 16,
  parameter int v_blank = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  output state_t                        state,
  output logic [$clog2(xmax+1)-1:0]     x,
  output logic [$clog2(ymax+1)-1:0]     y,
  output logic                          frame_end
);

  localparam int xw   = $clog2(xmax + 1);
  localparam int yw   = $clog2(ymax + 1);
  localparam int bmax = (h_blank > v_blank) ? h_blank : v_blank;
  localparam int bw   = $clog2(bmax + 1);

  state_t          state_q, state_d;
  logic [xw-1:0]   x_q, x_d;
  logic [yw-1:0]   y_q, y_d;
  logic [bw-1:0]   bcnt_q, bcnt_d;

  // State and counter registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state and counter update. enable is only consulted in IDLE and at
  // the end of VBLANK, so dropping it mid-frame lets the frame finish.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bcnt_d    = bcnt_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = VBLANK;
          bcnt_d  = '0;
        end
      end
      VBLANK: begin
        if (bcnt_q == bw'(v_blank - 1)) begin
          bcnt_d = '0;
          if (enable) begin
            state_d = HBLANK;
            y_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + bw'(1);
        end
      end
      HBLANK: begin
        if (bcnt_q == bw'(h_blank - 1)) begin
          bcnt_d = '0;
          x_d    = '0;
          if (y_q == yw'(ymax)) begin
            state_d   = VBLANK;
            frame_end = 1'b1;
          end else begin
            state_d = ACTIVE;
          end
        end else begin
          bcnt_d = bcnt_q + bw'(1);
        end
      end
      ACTIVE: begin
        if (x_q == xw'(xmax - 1)) begin
          x_d     = '0;
          y_d     = y_q + yw'(1);
          state_d = HBLANK;
        end else begin
          x_d = x_q + xw'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;
  assign x     = x_q;
  assign y     = y_q;

endmodule

// File: rtl/vsync_hsync_source.sv
// Camera-style sync source: wraps an ROI pixel stream in padding and
// hsync/vsync timing. All outputs are registered (1-cycle latency) except
// pix_in_ready, which is combinational from the current position.
// Optional build macro TEST_PATTERN_EN adds a test_pattern input that
// replaces ROI pixels with (x+y).
module vsync_hsync_source
  import camera_timing_pkg::*;
#(
  parameter int roi_width      = 320,
  parameter int roi_height     = 240,
  parameter int left_padding   = 2,
  parameter int right_padding  = 2,
  parameter int top_padding    = 2,
  parameter int bottom_padding = 2,
  parameter int h_blank        = 16,
  parameter int v_blank        = 64,
  parameter int pix_width      = 8,
  parameter int pad_value      = 0
) (
  input  logic                 pixclk_in,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [pix_width-1:0] pix_in,
  input  logic                 pix_in_valid,
`ifdef TEST_PATTERN_EN
  input  logic                 test_pattern,
`endif
  output logic                 pix_in_ready,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic [pix_width-1:0] pix_out,
  output logic                 underrun,
  output logic                 frame_done
);

  localparam int xmax = roi_width + left_padding + right_padding;
  localparam int ymax = roi_height + top_padding + bottom_padding;
  localparam int xw   = $clog2(xmax + 1);
  localparam int yw   = $clog2(ymax + 1);
  localparam logic [pix_width-1:0] pad_px = pix_width'(pad_value);

  state_t          state;
  logic [xw-1:0]   x;
  logic [yw-1:0]   y;
  logic            frame_end;
  logic            roi;
  logic [pix_width-1:0] pix_d;
  logic            starve;

  sync_counter #(
    .xmax    (xmax),
    .ymax    (ymax),
    .h_blank (h_blank),
    .v_blank (v_blank)
  ) u_sync_counter (
    .clk       (pixclk_in),
    .rst_n     (rst_n),
    .enable    (enable),
    .state     (state),
    .x         (x),
    .y         (y),
    .frame_end (frame_end)
  );

  assign roi = (state == ACTIVE) &&
               in_roi_window(32'(x), 32'(y),
                             32'(left_padding), 32'(roi_width),
                             32'(top_padding),  32'(roi_height));

`ifdef TEST_PATTERN_EN
  logic [pix_width-1:0] pattern_px;
  assign pattern_px = pix_width'(32'(x) + 32'(y));
`endif

  // Handshake and next pixel selection: only ROI slots accept data; a
  // missing pixel is padded and flagged, timing never stalls.
  always_comb begin
    pix_in_ready = 1'b0;
    pix_d        = pad_px;
    starve       = 1'b0;
    if (rst_n && roi) begin
`ifdef TEST_PATTERN_EN
      if (test_pattern) pix_d = pattern_px;
      else
`endif
      begin
        pix_in_ready = 1'b1;
        if (pix_in_valid) pix_d = pix_in;
        else              starve = 1'b1;
      end
    end
  end

  // Registered outputs, one cycle behind the timing engine.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      pix_out    <= pad_px;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      hsync_out  <= (state == ACTIVE);
      vsync_out  <= (state == HBLANK) || (state == ACTIVE);
      pix_out    <= pix_d;
      frame_done <= frame_end;
      if (starve) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vsync_hsync_source.sv
// Randomized bench for vsync_hsync_source with a frame-position reference
// model (ROI 4x3, padding 1, h_blank 2, v_blank 3).
module tb_vsync_hsync_source;

  localparam int RW = 4, RH = 3, LP = 1, RP = 1, TP = 1, BP = 1;
  localparam int HB = 2, VB = 3;
  localparam int XMAX = RW + LP + RP;
  localparam int YMAX = RH + TP + BP;
  localparam int LL   = HB + XMAX;
  localparam int PER  = VB + (YMAX + 1) * HB + YMAX * XMAX;

  logic       clk = 1'b0;
  logic       rst_n, enable, pix_in_valid;
  logic [7:0] pix_in;
  logic       pix_in_ready, hsync_out, vsync_out, underrun, frame_done;
  logic [7:0] pix_out;
  bit         tp_mode = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

`ifdef TEST_PATTERN_EN
  logic test_pattern;
  assign test_pattern = tp_mode;
`endif

  vsync_hsync_source #(
    .roi_width(RW), .roi_height(RH),
    .left_padding(LP), .right_padding(RP),
    .top_padding(TP), .bottom_padding(BP),
    .h_blank(HB), .v_blank(VB), .pix_width(8), .pad_value(0)
  ) dut (
    .pixclk_in    (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
`ifdef TEST_PATTERN_EN
    .test_pattern (test_pattern),
`endif
    .pix_in_ready (pix_in_ready),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .pix_out      (pix_out),
    .underrun     (underrun),
    .frame_done   (frame_done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position t in [0, PER) while running.
  bit         m_run = 1'b0, m_und = 1'b0;
  int         m_t = 0;
  bit         e_h = 1'b0, e_v = 1'b0, e_fd = 1'b0, e_und = 1'b0;
  logic [7:0] e_pix = 8'h00;

  initial begin
    int st, mx, my, u, off;
    int hrun, vs_cnt, xfer, miss, fd_last, line_idx, cyc;
    bit roi;
    hrun = 0; vs_cnt = 0; xfer = 0; miss = 0; fd_last = -1; line_idx = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_hsync", 32'(hsync_out), 0);
        chk("rst_vsync", 32'(vsync_out), 0);
        chk("rst_pix", 32'(pix_out), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_ready", 32'(pix_in_ready), 0);
        m_run = 0; m_t = 0; m_und = 0;
        e_h = 0; e_v = 0; e_fd = 0; e_und = 0; e_pix = 8'h00;
        hrun = 0; vs_cnt = 0; xfer = 0; miss = 0; fd_last = -1; line_idx = 0;
      end else begin
        chk("hsync", 32'(hsync_out), 32'(e_h));
        chk("vsync", 32'(vsync_out), 32'(e_v));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("underrun", 32'(underrun), 32'(e_und));
        chk("pix_out", 32'(pix_out), 32'(e_pix));

        if (hsync_out) begin
`ifdef TEST_PATTERN_EN
          if (tp_mode && line_idx == 1 && hrun >= 1 && hrun <= 4)
            chk("tp_line1", 32'(pix_out), 32'(hrun + 1));
`endif
          hrun++;
        end else if (hrun != 0) begin
          chk("hsync_run", 32'(hrun), 6);
          hrun = 0;
          line_idx++;
        end
        if (vsync_out) vs_cnt++;
        if (frame_done) begin
          chk("vsync_len", 32'(vs_cnt), 42);
          if (fd_last >= 0) chk("frame_period", 32'(cyc - fd_last), 45);
          chk("roi_slots", 32'(xfer + miss), tp_mode ? 32'd0 : 32'd12);
          fd_last = cyc; vs_cnt = 0; xfer = 0; miss = 0; line_idx = 0;
        end

        st = 0; mx = 0; my = 0;
        if (m_run) begin
          if (m_t < VB) st = 1;
          else begin
            u = m_t - VB; my = u / LL; off = u % LL;
            if (off < HB) st = 2;
            else begin st = 3; mx = off - HB; end
          end
        end
        roi = (st == 3) && mx >= LP && mx < LP + RW && my >= TP && my < TP + RH;

        chk("ready", 32'(pix_in_ready), 32'(roi && !tp_mode));
        if (pix_in_ready && pix_in_valid) xfer++;
        if (roi && !tp_mode && !pix_in_valid) miss++;

        e_h  = (st == 3);
        e_v  = (st == 2) || (st == 3);
        e_fd = m_run && (m_t == PER - 1);
        if (!roi)         e_pix = 8'h00;
        else if (tp_mode) e_pix = 8'((mx + my) % 256);
        else if (pix_in_valid) e_pix = pix_in;
        else begin e_pix = 8'h00; m_und = 1; end
        e_und = m_und;

        if (!m_run) begin
          if (enable) begin m_run = 1; m_t = 0; end
        end else if (m_t == VB - 1 && !enable) m_run = 0;
        else if (m_t == PER - 1) m_t = 0;
        else m_t++;
        if (!m_run) fd_last = -1;
      end
    end
  end

  task automatic step(input int vmode);
    @(posedge clk); #2;
    pix_in = 8'($urandom);
    if (vmode == 1) pix_in_valid = ($urandom_range(3, 0) != 0);
    else            pix_in_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int nroi, fdc, vsc;
    bit seen;
    rst_n = 1'b0; enable = 1'b0; pix_in_valid = 1'b0; pix_in = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("init_hsync", 32'(hsync_out), 0);
    chk("init_pix", 32'(pix_out), 0);
    rst_n = 1'b1;

    // Nominal streaming, valid held high.
    enable = 1'b1; pix_in_valid = 1'b1;
    repeat (140) step(0);
    chk("nominal_no_underrun", 32'(underrun), 0);

    // Starve the second ROI pixel.
    do_reset();
    nroi = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #2;
      pix_in = 8'($urandom);
      pix_in_valid = 1'b1;
      if (pix_in_ready) begin
        nroi++;
        if (nroi == 2) begin
          chk("underrun_before", 32'(underrun), 0);
          pix_in_valid = 1'b0;
        end
      end
    end
    chk("underrun_sticky", 32'(underrun), 1);

    // Random valid and data.
    repeat (150) step(1);

    // Drop enable on line 2: frame completes, then idle.
    do_reset();
    nroi = 0; seen = 0;
    for (int i = 0; i < 200 && nroi < 5; i++) begin
      step(0);
      if (pix_in_ready) nroi++;
    end
    chk("reach_line2", 32'(nroi), 5);
    enable = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(0);
      if (frame_done) seen = 1;
    end
    chk("frame_completes", 32'(seen), 1);
    repeat (5) step(0);
    chk("idle_vsync", 32'(vsync_out), 0);
    chk("idle_hsync", 32'(hsync_out), 0);
    fdc = 0; vsc = 0;
    for (int i = 0; i < 60; i++) begin
      step(0);
      if (frame_done) fdc++;
      if (vsync_out) vsc++;
    end
    chk("idle_no_frame", 32'(fdc), 0);
    chk("idle_vsync_cnt", 32'(vsc), 0);
    enable = 1'b1;

    // Reset mid-ACTIVE.
    do_reset();
    nroi = 0;
    for (int i = 0; i < 200 && nroi < 7; i++) begin
      step(0);
      if (pix_in_ready) nroi++;
    end
    chk("reach_mid_active", 32'(nroi), 7);
    rst_n = 1'b0;
    #1;
    chk("abort_hsync", 32'(hsync_out), 0);
    chk("abort_vsync", 32'(vsync_out), 0);
    chk("abort_ready", 32'(pix_in_ready), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (100) step(0);

`ifdef TEST_PATTERN_EN
    tp_mode = 1'b1;
    do_reset();
    repeat (100) step(1);
    chk("tp_no_underrun", 32'(underrun), 0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vsync_hsync_source.md
VSYNC_HSYNC_SOURCE -- requirements
Module: vsync_hsync_source

Interface
REQ-001 SHALL have parameter roi_width, default 320, active pixels per line.
REQ-002 SHALL have parameter roi_height, default 240, active lines per frame.
REQ-003 SHALL have parameters left_padding, right_padding, top_padding and bottom_padding, default 2 each, giving pad pixels or lines around the ROI.
REQ-004 SHALL have parameter h_blank, default 16, hsync-low cycles after each line.
REQ-005 SHALL have parameter v_blank, default 64, cycles with vsync and hsync low between frames.
REQ-006 SHALL have parameter pix_width, default 8, pixel bits.
REQ-007 SHALL have parameter pad_value, default 0, value driven on pad pixels.
REQ-008 SHALL have these ports (name, direction, width, meaning):
- pixclk_in, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, start and continue frames.
- pix_in, input, pix_width, ROI pixel stream data.
- pix_in_valid, input, 1, stream data valid.
- pix_in_ready, output, 1, stream data accepted this cycle.
- hsync_out, output, 1, high during line pixels.
- vsync_out, output, 1, high during frame.
- pix_out, output, pix_width, camera pixel.
- underrun, output, 1, sticky starvation flag.
- frame_done, output, 1, one-cycle pulse at frame end.

Function
REQ-009 SHALL derive xmax = roi_width + left_padding + right_padding and ymax = roi_height + top_padding + bottom_padding.
REQ-010 SHALL size the x and y counters to $clog2(xmax+1) and $clog2(ymax+1) bits, with no wrap inside a frame.
REQ-011 SHALL implement the state machine IDLE, VBLANK, HBLANK and ACTIVE:
- IDLE to VBLANK when enable=1.
- VBLANK lasts v_blank cycles, then goes to HBLANK with y=0 if enable=1, else to IDLE.
- HBLANK lasts h_blank cycles, then goes to VBLANK if y==ymax, else to ACTIVE.
- ACTIVE lasts xmax cycles with x counting 0..xmax-1, then goes to HBLANK with y incremented.
REQ-012 SHALL register all outputs, each reflecting the state and counter values of the previous cycle, for a fixed latency of 1 cycle.
REQ-013 SHALL drive vsync_out=1 in the HBLANK and ACTIVE states, and 0 otherwise.
REQ-014 SHALL drive hsync_out=1 only in the ACTIVE state.
REQ-015 SHALL define ROI pixels as ACTIVE with left_padding <= x < left_padding+roi_width and top_padding <= y < top_padding+roi_height.
REQ-016 SHALL drive pix_in_ready combinationally high only on ROI pixels, and record a transfer when pix_in_valid and pix_in_ready are both high.
REQ-017 SHALL put the transferred pix_in on pix_out in the next cycle.
REQ-018 SHALL drive pix_out=pad_value on non-ROI pixels and outside ACTIVE.
REQ-019 SHALL, on an ROI pixel with pix_in_valid=0, output pad_value, set underrun, and keep timing unchanged.
REQ-020 SHALL clear underrun only on reset.
REQ-021 SHALL pulse frame_done for one cycle on the HBLANK-to-VBLANK transition.
REQ-022 SHALL, when enable falls mid-frame, finish the current frame and its VBLANK, then enter IDLE.
REQ-023 SHALL ignore pix_in_valid outside ROI pixels, with no transfer recorded.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, x=0, y=0, hsync_out=0, vsync_out=0, pix_out=pad_value, underrun=0 and frame_done=0.
REQ-025 SHALL hold pix_in_ready=0 during reset.
REQ-026 SHALL let reset abort any frame immediately, mid-line included.
REQ-027 SHALL restart from IDLE after reset release.

Configuration
REQ-028 SHALL, with TEST_PATTERN_EN defined, add an input test_pattern (1 bit).
REQ-029 SHALL, when test_pattern=1 under TEST_PATTERN_EN, drive ROI pixels as (x+y) truncated to pix_width, hold pix_in_ready=0, and never set underrun.
REQ-030 SHALL, with TEST_PATTERN_EN undefined, have no test_pattern port and no pattern logic.

Structure
REQ-031 SHALL place the state enum (IDLE, VBLANK, HBLANK, ACTIVE) in shared package camera_timing_pkg.
REQ-032 SHALL define its ROI-window comparison helper function in camera_timing_pkg.
REQ-033 SHALL implement the state, x, y and blank counters in a single sub-module named sync_counter; pixel and handshake muxing stays in the top module.

Verification
(All scenarios use roi 4x3, padding 1 each, h_blank 2, v_blank 3, held valid unless stated.)
REQ-034 SHALL check: enable=1 -> vsync_out high 42 cycles per frame, frame period 45 cycles, frame_done once per frame.
REQ-035 SHALL check: each line -> hsync_out high exactly 6 cycles; 12 transfers per frame; pix_out order equals pix_in order; pads read 0.
REQ-036 SHALL check: pix_in_valid=0 on the 2nd ROI pixel -> pix_out=0 there; underrun=1 permanently; sync timing unchanged.
REQ-037 SHALL check: enable dropped on line 2 -> frame completes, VBLANK runs 3 cycles, then IDLE with all syncs 0.
REQ-038 SHALL check: rst_n asserted mid-ACTIVE -> the same cycle gives hsync_out=0, vsync_out=0 and pix_in_ready=0, and the next frame starts cleanly.
REQ-039 SHALL check, with TEST_PATTERN_EN and test_pattern=1: line y=1 ROI shows pix_out 2,3,4,5, and pix_in_ready stays 0.
